// File: rtl/cic_pkg.sv
// Shared types and elaboration helpers for the multi-channel CIC decimator.
package cic_pkg;

   localparam int unsigned MAX_ORDER    = 4;
   localparam int unsigned MAX_DEC_LOG2 = 6;

   // Wide enough for the largest legal decimation ratio; unused upper bits stay zero.
   typedef logic [MAX_DEC_LOG2-1:0] phase_t;

   function automatic int unsigned acc_w(input int unsigned in_w,
                                         input int unsigned order,
                                         input int unsigned dec_log2);
      return in_w + 1 + order * dec_log2;
   endfunction

   function automatic bit params_legal(input int unsigned order,
                                       input int unsigned dec_log2);
      return (order >= 1) && (order <= MAX_ORDER) &&
             (dec_log2 >= 1) && (dec_log2 <= MAX_DEC_LOG2);
   endfunction

endpackage

// File: rtl/cic_decimator_mc_if.sv
// Sample-side bus of the CIC decimator: counter inputs, control and decimated outputs.
interface cic_decimator_mc_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned IN_W   = 12,
   parameter int unsigned OUT_W  = 9
);
   logic                     enable;
   logic                     clear;
   logic [NUM_CH*IN_W-1:0]   counter_p;
   logic [NUM_CH*IN_W-1:0]   counter_n;
   logic [NUM_CH*OUT_W-1:0]  channel_output;
   logic                     out_valid;
   logic [NUM_CH-1:0]        sat_flag;

   modport master (
      output enable, clear, counter_p, counter_n,
      input  channel_output, out_valid, sat_flag
   );

   modport slave (
      input  enable, clear, counter_p, counter_n,
      output channel_output, out_valid, sat_flag
   );
endinterface

// File: rtl/cic_channel.sv
// One CIC channel: counter difference, pipelined integrators, combs on tick, shift and clip.
module cic_channel
   import cic_pkg::*;
#(
   parameter int unsigned IN_W     = 12,
   parameter int unsigned ORDER    = 2,
   parameter int unsigned DEC_LOG2 = 3,
   parameter int unsigned SHIFT    = 3,
   parameter int unsigned OUT_W    = 9
) (
   input  logic                    CLK_24M,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    clear,
   input  logic                    tick,
   input  logic [IN_W-1:0]         counter_p,
   input  logic [IN_W-1:0]         counter_n,
   output logic signed [OUT_W-1:0] channel_output,
   output logic                    sat_flag
);
   localparam int unsigned ACC_W = acc_w(IN_W, ORDER, DEC_LOG2);
   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((longint'(1) <<< (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

   logic signed [IN_W:0]      diff_c;
   logic signed [ACC_W-1:0]   diff_ext_c;
   logic signed [ACC_W-1:0]   integ    [ORDER];
   logic signed [ACC_W-1:0]   dly      [ORDER];
   logic signed [ACC_W-1:0]   comb_in_c[ORDER];
   logic signed [ACC_W-1:0]   comb_out_c;
   logic signed [ACC_W-1:0]   shifted_c;
   logic                      clip_hi_c;
   logic                      clip_lo_c;
   logic signed [OUT_W-1:0]   y_c;

   assign diff_c     = $signed({1'b0, counter_p}) - $signed({1'b0, counter_n});
   assign diff_ext_c = ACC_W'(diff_c);

   // Comb chain from the pre-edge last integrator; comb_in_c[i] is what dly[i] captures.
   always_comb begin : comb_chain
      logic signed [ACC_W-1:0] stage;
      stage = integ[ORDER-1];
      for (int i = 0; i < ORDER; i++) begin
         comb_in_c[i] = stage;
         stage        = stage - dly[i];
      end
      comb_out_c = stage;
   end

   assign shifted_c = comb_out_c >>> SHIFT;
   assign clip_hi_c = shifted_c > Y_MAX;
   assign clip_lo_c = shifted_c < Y_MIN;
   assign y_c       = clip_hi_c ? OUT_W'(Y_MAX) :
                      clip_lo_c ? OUT_W'(Y_MIN) : OUT_W'(shifted_c);

   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ORDER; i++) begin
            integ[i] <= '0;
            dly[i]   <= '0;
         end
         channel_output <= '0;
         sat_flag       <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < ORDER; i++) begin
            integ[i] <= '0;
            dly[i]   <= '0;
         end
         channel_output <= '0;
         sat_flag       <= 1'b0;
      end else if (enable) begin
         // Integrators wrap modulo 2**ACC_W; the combs undo the wrap exactly.
         integ[0] <= integ[0] + diff_ext_c;
         for (int i = 1; i < ORDER; i++) begin
            integ[i] <= integ[i] + integ[i-1];
         end
         if (tick) begin
            for (int i = 0; i < ORDER; i++) begin
               dly[i] <= comb_in_c[i];
            end
            channel_output <= y_c;
            if (clip_hi_c || clip_lo_c) begin
               sat_flag <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator top: shared decimation phase and strobe, one cic_channel per channel.
module cic_decimator_mc
   import cic_pkg::*;
#(
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned IN_W     = 12,
   parameter int unsigned ORDER    = 2,
   parameter int unsigned DEC_LOG2 = 3,
   parameter int unsigned SHIFT    = 3,
   parameter int unsigned OUT_W    = 9
) (
   input  logic               CLK_24M,
   input  logic               reset,
   cic_decimator_mc_if.slave  bus
);
   localparam phase_t PHASE_LAST = phase_t'((1 << DEC_LOG2) - 1);

   if (!params_legal(ORDER, DEC_LOG2)) begin : g_bad_params
      $error("cic_decimator_mc: ORDER must be 1..4 and DEC_LOG2 1..6");
   end
   if (OUT_W > acc_w(IN_W, ORDER, DEC_LOG2)) begin : g_bad_out_w
      $error("cic_decimator_mc: OUT_W exceeds the accumulator width");
   end

   phase_t phase;
   logic   tick_c;

   assign tick_c = bus.enable & ~bus.clear & (phase == PHASE_LAST);

   // Decimation phase; out_valid follows the tick edge by one cycle and drops when frozen.
   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         phase         <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= tick_c;
         if (bus.clear) begin
            phase <= '0;
         end else if (bus.enable) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + phase_t'(1);
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      cic_channel #(
         .IN_W     (IN_W),
         .ORDER    (ORDER),
         .DEC_LOG2 (DEC_LOG2),
         .SHIFT    (SHIFT),
         .OUT_W    (OUT_W)
      ) u_channel (
         .CLK_24M        (CLK_24M),
         .reset          (reset),
         .enable         (bus.enable),
         .clear          (bus.clear),
         .tick           (tick_c),
         .counter_p      (bus.counter_p[k*IN_W +: IN_W]),
         .counter_n      (bus.counter_n[k*IN_W +: IN_W]),
         .channel_output (bus.channel_output[k*OUT_W +: OUT_W]),
         .sat_flag       (bus.sat_flag[k])
      );
   end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Bench for cic_decimator_mc: default instance plus an ORDER=4/R=64 instance, both scoreboarded.
module tb_cic_decimator_mc;

   typedef struct packed {
      int         y0;
      int         y1;
      logic [1:0] sat;
   } exp_t;

   typedef struct {
      int         p0, n0, p1, n1;
      bit         clr;
      int         exp0, exp1;
      logic [1:0] esat;
   } vec_t;

   logic CLK_24M = 1'b0;
   logic reset;
   always #5 CLK_24M = ~CLK_24M;

   cic_decimator_mc_if #(.NUM_CH(2), .IN_W(12), .OUT_W(9))  bus_a ();
   cic_decimator_mc_if #(.NUM_CH(2), .IN_W(12), .OUT_W(12)) bus_b ();

   cic_decimator_mc #(.NUM_CH(2), .IN_W(12), .ORDER(2), .DEC_LOG2(3), .SHIFT(3), .OUT_W(9))
      dut_a (.CLK_24M(CLK_24M), .reset(reset), .bus(bus_a));
   cic_decimator_mc #(.NUM_CH(2), .IN_W(12), .ORDER(4), .DEC_LOG2(6), .SHIFT(24), .OUT_W(12))
      dut_b (.CLK_24M(CLK_24M), .reset(reset), .bus(bus_b));

   int errors = 0;
   int checks = 0;

   // Wide-integer reference: no wrap, 64-bit state is ample for these runs.
   int     p_order[2] = '{2, 4};
   int     p_dl   [2] = '{3, 6};
   int     p_shift[2] = '{3, 24};
   int     p_outw [2] = '{9, 12};
   longint m_int  [2][2][4];
   longint m_dly  [2][2][4];
   int     m_phase[2];
   bit     m_sat  [2][2];
   exp_t   q_a[$];
   exp_t   q_b[$];
   exp_t   cap_gap[$];
   exp_t   cap_ref[$];
   int     cap_sel = 0;

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   function automatic int get_out(input int d, input int k);
      logic signed [8:0]  va;
      logic signed [11:0] vb;
      if (d == 0) begin
         va = bus_a.channel_output[k*9 +: 9];
         return int'(va);
      end
      vb = bus_b.channel_output[k*12 +: 12];
      return int'(vb);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = 0;
         for (int c = 0; c < 2; c++) begin
            m_sat[d][c] = 1'b0;
            for (int i = 0; i < 4; i++) begin
               m_int[d][c][i] = 0;
               m_dly[d][c][i] = 0;
            end
         end
      end
      q_a.delete();
      q_b.delete();
   endtask

   task automatic model_edge(input int d, input bit en, input bit clr,
                             input longint d0, input longint d1);
      int     r;
      longint x, c, y, lim;
      int     ys[2];
      exp_t   e;
      if (clr) begin
         m_phase[d] = 0;
         for (int ch = 0; ch < 2; ch++) begin
            m_sat[d][ch] = 1'b0;
            for (int i = 0; i < 4; i++) begin
               m_int[d][ch][i] = 0;
               m_dly[d][ch][i] = 0;
            end
         end
      end else if (en) begin
         r = 1 << p_dl[d];
         if (m_phase[d] == r - 1) begin
            for (int ch = 0; ch < 2; ch++) begin
               x = m_int[d][ch][p_order[d]-1];
               for (int i = 0; i < p_order[d]; i++) begin
                  c = x - m_dly[d][ch][i];
                  m_dly[d][ch][i] = x;
                  x = c;
               end
               y   = x >>> p_shift[d];
               lim = longint'(1) <<< (p_outw[d] - 1);
               if (y > lim - 1) begin y = lim - 1; m_sat[d][ch] = 1'b1; end
               if (y < -lim)    begin y = -lim;    m_sat[d][ch] = 1'b1; end
               ys[ch] = int'(y);
            end
            e.y0  = ys[0];
            e.y1  = ys[1];
            e.sat = {m_sat[d][1], m_sat[d][0]};
            if (d == 0) q_a.push_back(e); else q_b.push_back(e);
         end
         for (int ch = 0; ch < 2; ch++) begin
            for (int i = p_order[d] - 1; i >= 1; i--) begin
               m_int[d][ch][i] = m_int[d][ch][i] + m_int[d][ch][i-1];
            end
            m_int[d][ch][0] = m_int[d][ch][0] + ((ch == 0) ? d0 : d1);
         end
         m_phase[d] = (m_phase[d] + 1) % r;
      end
   endtask

   task automatic check_valid(input int d);
      logic       v;
      exp_t       e;
      exp_t       got;
      int         qs;
      v  = (d == 0) ? bus_a.out_valid : bus_b.out_valid;
      qs = (d == 0) ? q_a.size() : q_b.size();
      got.y0  = get_out(d, 0);
      got.y1  = get_out(d, 1);
      got.sat = (d == 0) ? bus_a.sat_flag : bus_b.sat_flag;
      if (v) begin
         if (d == 0 && cap_sel == 1) cap_gap.push_back(got);
         if (d == 0 && cap_sel == 2) cap_ref.push_back(got);
         if (qs == 0) begin
            chk($sformatf("sb%0d_spurious_valid", d), 1, 0);
         end else begin
            e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
            chk($sformatf("sb%0d_ch0", d), got.y0, e.y0);
            chk($sformatf("sb%0d_ch1", d), got.y1, e.y1);
            chk($sformatf("sb%0d_sat", d), got.sat, e.sat);
         end
      end else if (qs != 0) begin
         chk($sformatf("sb%0d_missing_valid", d), 0, 1);
         if (d == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
      end
   endtask

   task automatic step();
      longint da0, da1, db0, db1;
      bit     ena, cla, enb, clb;
      da0 = longint'(bus_a.counter_p[11:0])  - longint'(bus_a.counter_n[11:0]);
      da1 = longint'(bus_a.counter_p[23:12]) - longint'(bus_a.counter_n[23:12]);
      db0 = longint'(bus_b.counter_p[11:0])  - longint'(bus_b.counter_n[11:0]);
      db1 = longint'(bus_b.counter_p[23:12]) - longint'(bus_b.counter_n[23:12]);
      ena = bus_a.enable; cla = bus_a.clear;
      enb = bus_b.enable; clb = bus_b.clear;
      @(posedge CLK_24M);
      if (reset) begin
         model_edge(0, ena, cla, da0, da1);
         model_edge(1, enb, clb, db0, db1);
      end
      #1;
      check_valid(0);
      check_valid(1);
   endtask

   task automatic set_a(input int p0, input int n0, input int p1, input int n1);
      bus_a.counter_p = {12'(p1), 12'(p0)};
      bus_a.counter_n = {12'(n1), 12'(n0)};
   endtask

   task automatic clear_a();
      bus_a.clear = 1'b1;
      step();
      bus_a.clear = 1'b0;
   endtask

   // Steps until out_valid on dut_a; returns the edge count, or -1 when the bound expires.
   task automatic edges_to_valid(output int n);
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus_a.out_valid) begin n = i; break; end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t tbl[5];
      int   n, vcount;

      tbl[0] = '{p0:105, n0:100, p1:105, n1:100, clr:0, exp0:40,  exp1:40,   esat:2'b00};
      tbl[1] = '{p0:0,   n0:5,   p1:0,   n1:5,   clr:0, exp0:-40, exp1:-40,  esat:2'b00};
      tbl[2] = '{p0:200, n0:100, p1:105, n1:100, clr:0, exp0:255, exp1:40,   esat:2'b01};
      tbl[3] = '{p0:105, n0:100, p1:0,   n1:5,   clr:1, exp0:40,  exp1:-40,  esat:2'b00};
      tbl[4] = '{p0:0,   n0:5,   p1:100, n1:200, clr:1, exp0:-40, exp1:-256, esat:2'b10};

      reset = 1'b0;
      bus_a.enable = 1'b0; bus_a.clear = 1'b0; set_a(0, 0, 0, 0);
      bus_b.enable = 1'b0; bus_b.clear = 1'b0;
      bus_b.counter_p = '0; bus_b.counter_n = '0;
      model_reset();
      repeat (2) @(posedge CLK_24M);
      #1;
      chk("reset_out_valid", bus_a.out_valid, 0);
      chk("reset_ch0", get_out(0, 0), 0);
      chk("reset_sat", bus_a.sat_flag, 0);
      @(negedge CLK_24M);
      reset = 1'b1;

      // Reset mid-stream with d=5 running, then first-strobe latency.
      set_a(105, 100, 105, 100);
      bus_a.enable = 1'b1;
      repeat (30) step();
      #2 reset = 1'b0;
      #1;
      chk("async_rst_valid", bus_a.out_valid, 0);
      chk("async_rst_ch0", get_out(0, 0), 0);
      chk("async_rst_ch1", get_out(0, 1), 0);
      chk("async_rst_sat", bus_a.sat_flag, 0);
      model_reset();
      @(negedge CLK_24M);
      reset = 1'b1;
      edges_to_valid(n);
      chk("first_valid_edges", n, 8);

      // Constant-difference table: steady value, strobe period and sticky saturation.
      for (int t = 0; t < 5; t++) begin
         if (tbl[t].clr) begin
            clear_a();
            chk($sformatf("tbl%0d_clear_out", t), get_out(0, 0), 0);
            chk($sformatf("tbl%0d_clear_sat", t), bus_a.sat_flag, 0);
         end
         set_a(tbl[t].p0, tbl[t].n0, tbl[t].p1, tbl[t].n1);
         vcount = 0;
         for (int i = 0; i < 48; i++) begin
            step();
            if (bus_a.out_valid) vcount++;
         end
         chk($sformatf("tbl%0d_valid_count", t), vcount, 6);
         chk($sformatf("tbl%0d_ch0", t), get_out(0, 0), tbl[t].exp0);
         chk($sformatf("tbl%0d_ch1", t), get_out(0, 1), tbl[t].exp1);
         chk($sformatf("tbl%0d_sat", t), bus_a.sat_flag, tbl[t].esat);
      end

      // Enable gap of 13 cycles mid-frame versus an ungapped run.
      clear_a();
      set_a(105, 100, 97, 100);
      cap_sel = 1;
      repeat (12) step();
      bus_a.enable = 1'b0;
      vcount = 0;
      for (int i = 0; i < 13; i++) begin
         step();
         if (bus_a.out_valid) vcount++;
      end
      chk("gap_no_valid", vcount, 0);
      bus_a.enable = 1'b1;
      repeat (40) step();
      cap_sel = 0;
      clear_a();
      cap_sel = 2;
      repeat (52) step();
      cap_sel = 0;
      chk("gap_count", cap_gap.size(), 6);
      chk("ref_count", cap_ref.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < cap_gap.size() && i < cap_ref.size()) begin
            chk($sformatf("gap_seq%0d_ch0", i), cap_gap[i].y0, cap_ref[i].y0);
            chk($sformatf("gap_seq%0d_ch1", i), cap_gap[i].y1, cap_ref[i].y1);
         end
      end

      // Clear landing on a tick edge.
      clear_a();
      set_a(200, 100, 200, 100);
      repeat (31) step();
      chk("pre_clear_sat", bus_a.sat_flag, 2'b11);
      clear_a();
      chk("clear_tick_valid", bus_a.out_valid, 0);
      chk("clear_tick_ch0", get_out(0, 0), 0);
      chk("clear_tick_sat", bus_a.sat_flag, 0);
      edges_to_valid(n);
      chk("clear_next_valid_edges", n, 8);
      bus_a.enable = 1'b0;

      // Order 4, R=64: integrator wrap against the wide reference, then clipping.
      bus_b.clear = 1'b1;
      step();
      bus_b.clear = 1'b0;
      bus_b.counter_p = {12'd0, 12'd4095};
      bus_b.counter_n = {12'd4095, 12'd0};
      bus_b.enable = 1'b1;
      vcount = 0;
      for (int i = 0; i < 512; i++) begin
         step();
         if (bus_b.out_valid) vcount++;
      end
      chk("b_valid_count", vcount, 8);
      chk("b_ch0_clip", get_out(1, 0), 2047);
      chk("b_ch1_clip", get_out(1, 1), -2048);
      chk("b_sat", bus_b.sat_flag, 2'b11);

      chk("sb_a_drained", q_a.size(), 0);
      chk("sb_b_drained", q_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
